// File: rtl/sc_shiftseq_pkg.sv
// Shared state encoding and datapath control codes for the shift sequencer.
// Wide all-ones/all-zeros codes truncate cleanly to any configured select width.
package sc_shiftseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_LOAD   = 3'd2,
    S_SHIFT  = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [31:0] DEC_NONE  = '1;
  localparam logic [31:0] MUX_NONE  = '1;
  localparam logic [31:0] ALU_NOP   = '1;
  localparam logic [31:0] ALU_PASSA = '0;

  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;
  localparam logic [1:0] SH_HOLD  = 2'b11;

endpackage

// File: rtl/sc_shiftseq_counter.sv
// Loadable down-counter for the shift phase; saturates at zero.
// tc flags the last shift cycle (remaining is 1, or 0 as a safety net).
module sc_shiftseq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst)                        count <= '0;
    else if (load)                  count <= load_val;
    else if (dec && (count != '0))  count <= count - W'(1);
  end

  assign tc = (count <= W'(1));

endmodule

// File: rtl/sc_shift_sequencer.sv
// Run-time programmable select/load/shift/write sequencer for the RegSHIFTER datapath.
// Optional: define SC_SHIFTSEQ_ZEROSTOP_EN to end the shift phase early on a zero result.
module sc_shift_sequencer
  import sc_shiftseq_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_SHIFTCOUNT           = 4
) (
  input  logic                                      SC_SHIFTSEQ_CLOCK_50,
  input  logic                                      SC_SHIFTSEQ_Reset_InHigh,
  input  logic                                      SC_SHIFTSEQ_Start_InHigh,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTSEQ_Source_In,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_SHIFTSEQ_Dest_In,
  input  logic                                      SC_SHIFTSEQ_Direction_In,
  input  logic [DATAWIDTH_SHIFTCOUNT-1:0]           SC_SHIFTSEQ_Count_In,
  input  logic                                      SC_SHIFTSEQ_Zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_SHIFTSEQ_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTSEQ_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTSEQ_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_SHIFTSEQ_ALUSelection_Out,
  output logic                                      SC_SHIFTSEQ_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_SHIFTSEQ_RegSHIFTERShiftSelection_OutLow,
  output logic                                      SC_SHIFTSEQ_Busy_OutHigh,
  output logic                                      SC_SHIFTSEQ_Done_OutHigh
);

  localparam int DW = DATAWIDTH_DECODER_SELECTION;
  localparam int MW = DATAWIDTH_MUX_SELECTION;
  localparam int AW = DATAWIDTH_ALU_SELECTION;
  localparam int RW = DATAWIDTH_REGSHIFTER_SELECTION;
  localparam int CW = DATAWIDTH_SHIFTCOUNT;

  state_t        state, state_next;
  logic [MW-1:0] src;
  logic [DW-1:0] dst;
  logic          dir;
  logic [CW-1:0] cnt;
  logic          cnt_tc;
  logic          accept;
  logic          zero_stop;

  assign accept = (state == S_IDLE) && SC_SHIFTSEQ_Start_InHigh;

`ifdef SC_SHIFTSEQ_ZEROSTOP_EN
  assign zero_stop = (state == S_SHIFT) && !SC_SHIFTSEQ_Zero_InLow;
`else
  logic unused_zero;
  assign unused_zero = SC_SHIFTSEQ_Zero_InLow;
  assign zero_stop   = 1'b0;
`endif

  sc_shiftseq_counter #(.W(CW)) u_counter (
    .clk      (SC_SHIFTSEQ_CLOCK_50),
    .rst      (SC_SHIFTSEQ_Reset_InHigh),
    .load     (accept),
    .load_val (SC_SHIFTSEQ_Count_In),
    .dec      (state == S_SHIFT),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  // Operands are captured only on accept so a mid-sequence Start cannot disturb them.
  always_ff @(posedge SC_SHIFTSEQ_CLOCK_50) begin
    if (SC_SHIFTSEQ_Reset_InHigh) begin
      state <= S_IDLE;
      src   <= '0;
      dst   <= '1;
      dir   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        src <= SC_SHIFTSEQ_Source_In;
        dst <= SC_SHIFTSEQ_Dest_In;
        dir <= SC_SHIFTSEQ_Direction_In;
      end
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:   state_next = accept ? S_SELECT : S_IDLE;
      S_SELECT: state_next = S_LOAD;
      S_LOAD:   state_next = (cnt != '0) ? S_SHIFT : S_WRITE;
      S_SHIFT:  state_next = (zero_stop || cnt_tc) ? S_WRITE : S_SHIFT;
      S_WRITE:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    SC_SHIFTSEQ_DecoderSelectionWrite_Out       = DW'(DEC_NONE);
    SC_SHIFTSEQ_MUXSelectionBUSA_Out            = MW'(MUX_NONE);
    SC_SHIFTSEQ_MUXSelectionBUSB_Out            = MW'(MUX_NONE);
    SC_SHIFTSEQ_ALUSelection_Out                = AW'(ALU_NOP);
    SC_SHIFTSEQ_RegSHIFTERLoad_OutLow           = 1'b1;
    SC_SHIFTSEQ_RegSHIFTERShiftSelection_OutLow = RW'(SH_HOLD);
    SC_SHIFTSEQ_Busy_OutHigh                    = 1'b0;
    SC_SHIFTSEQ_Done_OutHigh                    = 1'b0;
    case (state)
      S_SELECT: begin
        SC_SHIFTSEQ_MUXSelectionBUSA_Out = src;
        SC_SHIFTSEQ_ALUSelection_Out     = AW'(ALU_PASSA);
        SC_SHIFTSEQ_Busy_OutHigh         = 1'b1;
      end
      S_LOAD: begin
        SC_SHIFTSEQ_MUXSelectionBUSA_Out  = src;
        SC_SHIFTSEQ_ALUSelection_Out      = AW'(ALU_PASSA);
        SC_SHIFTSEQ_RegSHIFTERLoad_OutLow = 1'b0;
        SC_SHIFTSEQ_Busy_OutHigh          = 1'b1;
      end
      S_SHIFT: begin
        // An early stop holds the shifter so the zero result is what gets written.
        if (!zero_stop)
          SC_SHIFTSEQ_RegSHIFTERShiftSelection_OutLow = dir ? RW'(SH_RIGHT) : RW'(SH_LEFT);
        SC_SHIFTSEQ_Busy_OutHigh = 1'b1;
      end
      S_WRITE: begin
        SC_SHIFTSEQ_DecoderSelectionWrite_Out = dst;
        SC_SHIFTSEQ_Busy_OutHigh              = 1'b1;
      end
      S_DONE: begin
        SC_SHIFTSEQ_Busy_OutHigh = 1'b1;
        SC_SHIFTSEQ_Done_OutHigh = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
